sm_rf_wb_arbiter: RTL and testbench

Write-back arbiter for the register file's single write port. Several producers (ALU result, load unit, CSR/misc) present write requests with valid/ready handshakes. The block grants one request per cycle and drives a registered write port: write enable, address and data. It sits between the execute/memory stages and the register file. It owns the file's only write-enable source.

---
 rtl/sm_rf_wb_pkg.sv | 19 +
 rtl/sm_rr_pick.sv | 33 +++
 rtl/sm_rf_wb_arbiter.sv | 113 +++++++++++
 tb/tb_sm_rf_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_rf_wb_pkg.sv
// Shared widths, constants and helpers for the register-file write-back arbiter.
// Requester slots follow the order ALU, LSU, CSR.
package sm_rf_wb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    // Pointer width for an n-entry rotation; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_rr_pick.sv
// Rotate-priority picker: first set request bit at or above ptr, wrapping.
// The grant is one-hot, or zero when no request is set.
module sm_rr_pick
    import sm_rf_wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_rf_wb_arbiter.sv
// Write-back arbiter driving the register file's single registered write port.
// SM_RF_WB_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module sm_rf_wb_arbiter
    import sm_rf_wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic             rf_stall,
    output logic             rf_we,
    output logic [AW-1:0]    rf_wa,
    output logic [DW-1:0]    rf_wd,
    output logic             busy
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] pick;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic          rf_we_d, rf_we_q;
    logic [AW-1:0] rf_wa_d, rf_wa_q;
    logic [DW-1:0] rf_wd_d, rf_wd_q;

    sm_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick)
    );

    // Ready is held low through reset so nothing transfers into a dead port.
    assign req_ready = (rst && !rf_stall) ? pick : '0;
    assign xfer      = |req_ready;
    assign busy      = |req_valid;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

`ifdef SM_RF_WB_ARB_RR_EN
    logic [PW-1:0] ptr_d, ptr_q;
    logic [PW-1:0] gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = PW'(i);
            end
        end
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // x0 writes still complete the handshake but never pulse the enable.
    always_comb begin
        rf_we_d = xfer && (sel_addr != AW'(ZERO_REG));
        rf_wa_d = xfer ? sel_addr : rf_wa_q;
        rf_wd_d = xfer ? sel_data : rf_wd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_sm_rf_wb_arbiter.sv
// Scoreboard bench for sm_rf_wb_arbiter: directed cases then held random traffic.
// Build with SM_RF_WB_ARB_RR_EN to match a round-robin DUT.
module tb_sm_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_stall;
    logic              rf_we;
    logic [AW-1:0]     rf_wa;
    logic [DW-1:0]     rf_wd;
    logic              busy;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int wcnt  = 0;
    int mptr  = 0;
    logic [AW-1:0]   mwa = '0;
    logic [DW-1:0]   mwd = '0;
    logic [NREQ-1:0] last_rdy = '0;

    sm_rf_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (rst && !rf_stall) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(mptr + k) % NREQ]) begin
                    r = '0;
                    r[(mptr + k) % NREQ] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic setreq(input int i, input logic v,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clr_all();
        for (int i = 0; i < NREQ; i++) setreq(i, 1'b0, '0, '0);
    endtask

    // One clock: check ready before the edge, check the write port after it.
    task automatic step();
        logic [NREQ-1:0] mr;
        exp_t e;
        @(negedge clk);
        mr = model_ready();
        last_rdy = mr;
        chk("ready", {61'd0, req_ready}, {61'd0, mr});
        chk("busy", {63'd0, busy}, {63'd0, |req_valid});
        e = '{we: 1'b0, wa: mwa, wd: mwd};
        for (int i = 0; i < NREQ; i++) begin
            if (mr[i]) begin
                mwa = req_addr[i*AW +: AW];
                mwd = req_data[i*DW +: DW];
                e   = '{we: (mwa != '0), wa: mwa, wd: mwd};
`ifdef SM_RF_WB_ARB_RR_EN
                mptr = (i + 1) % NREQ;
`endif
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("we", {63'd0, rf_we}, {63'd0, e.we});
            chk("wa", {59'd0, rf_wa}, {59'd0, e.wa});
            chk("wd", {32'd0, rf_wd}, {32'd0, e.wd});
        end
        if (rf_we) wcnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] ord;
        rst       = 1'b0;
        rf_stall  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        setreq(0, 1'b1, 5'd3, 32'h30);
        setreq(1, 1'b1, 5'd4, 32'h40);
        setreq(2, 1'b1, 5'd6, 32'h60);
        #1;
        chk("rst_rdy0", {61'd0, req_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_wa", {59'd0, rf_wa}, 64'd0);
        chk("rst_wd", {32'd0, rf_wd}, 64'd0);
        chk("rst_rdy", {61'd0, req_ready}, 64'd0);

        rst = 1'b1;
        #1;
        chk("rel_rdy", {61'd0, req_ready}, 64'b001);
        step();
        chk("rel_wa", {59'd0, rf_wa}, 64'd3);

        clr_all();
        setreq(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("single_rdy", {61'd0, req_ready}, 64'b010);
        step();
        chk("single_we", {63'd0, rf_we}, 64'd1);
        chk("single_wd", {32'd0, rf_wd}, 64'hDEADBEEF);
        clr_all();
        step();
        chk("single_off", {63'd0, rf_we}, 64'd0);

        setreq(2, 1'b1, 5'd12, 32'hC0C0);
        rf_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_rdy", {61'd0, req_ready}, 64'd0);
            step();
            chk("stall_we", {63'd0, rf_we}, 64'd0);
        end
        rf_stall = 1'b0;
        #1;
        chk("post_stall", {61'd0, req_ready}, 64'b100);
        step();
        clr_all();

        setreq(0, 1'b1, 5'd8, 32'h800);
        setreq(1, 1'b1, 5'd9, 32'h900);
        setreq(2, 1'b1, 5'd10, 32'hA00);
        wcnt = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef SM_RF_WB_ARB_RR_EN
            ord = NREQ'(1 << (k % NREQ));
`else
            ord = 3'b001;
`endif
            #1;
            chk("order", {61'd0, req_ready}, {61'd0, ord});
            step();
        end
        chk("pulses", 64'(wcnt), 64'd6);
        clr_all();
        step();

        setreq(0, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("x0_rdy", {63'd0, req_ready[0]}, 64'd1);
        step();
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        chk("x0_wa", {59'd0, rf_wa}, 64'd0);
        chk("x0_wd", {32'd0, rf_wd}, 64'h1234);
        clr_all();
        step();

        // Requesters hold until granted; occasionally withdraw early.
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_rdy[i]) begin
                    setreq(i, 1'b0, '0, '0);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    setreq(i, 1'b0, '0, '0);
                end
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    setreq(i, 1'b1, AW'($urandom_range(0, 31)), $urandom);
                end
            end
            rf_stall = ($urandom_range(0, 3) == 0);
            step();
        end
        rf_stall = 1'b0;
        clr_all();
        step();

        setreq(1, 1'b1, 5'd7, 32'h77);
        step();
        chk("pre_rst_we", {63'd0, rf_we}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_we", {63'd0, rf_we}, 64'd0);
        chk("arst_wa", {59'd0, rf_wa}, 64'd0);
        chk("arst_rdy", {61'd0, req_ready}, 64'd0);
        sb.delete();
        mptr = 0;
        mwa  = '0;
        mwd  = '0;
        clr_all();
        @(posedge clk);
        #1;
        chk("arst_hold", {63'd0, rf_we}, 64'd0);
        rst = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
